// File: rtl/logic_reduce_sweep_unit.sv
// Purpose : N-input reduction gate (AND/OR/XOR/NAND/NOR/XNOR) fed by external single-shot vectors or an on-chip truth-table sweep.
// Latency : 1 cycle from external accept to out_valid; each sweep vector is held HOLD_CYCLES cycles and its result pulses on the following cycle.
// Backpr. : in_ready drops while a sweep runs or sweep_start is asserted; the output has no backpressure.
// Optional: define SWEEP_SIGNATURE_EN to add the 16-bit sweep_sig shift-register output.
module logic_reduce_sweep_unit #(
  parameter int N           = 3,
  parameter int HOLD_CYCLES = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [2:0]   op,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  input  logic         sweep_start,
  output logic         sweep_busy,
  output logic         sweep_done,
  output logic         out_valid,
  output logic         out_data,
  output logic [N-1:0] out_vec,
  output logic         op_err
`ifdef SWEEP_SIGNATURE_EN
  ,
  output logic [15:0]  sweep_sig
`endif
);

  // One extra counter bit keeps the last-vector compare from wrapping to zero.
  localparam logic [N:0] LAST_VEC  = {1'b0, {N{1'b1}}};
  localparam logic [N:0] VEC_ONE   = {{N{1'b0}}, 1'b1};
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t       state;
  logic [2:0]   op_q;
  logic [N:0]   vec_cnt;
  logic [7:0]   hold_cnt;
  logic [1:0]   ext_res;
  logic [1:0]   sweep_res;

  // Returns {op_err, result}; reserved ops force the result low.
  function automatic logic [1:0] reduce_f(input logic [2:0] sel, input logic [N-1:0] v);
    logic [1:0] r;
    r = 2'b00;
    case (sel)
      3'd0: r = {1'b0, &v};
      3'd1: r = {1'b0, |v};
      3'd2: r = {1'b0, ^v};
      3'd3: r = {1'b0, ~&v};
      3'd4: r = {1'b0, ~|v};
      3'd5: r = {1'b0, ~^v};
      default: r = 2'b10;
    endcase
    return r;
  endfunction

  assign ext_res   = reduce_f(op, in_data);
  assign sweep_res = reduce_f(op_q, vec_cnt[N-1:0]);

  // Sweep start takes priority over an external vector in the same cycle.
  assign in_ready = (state == IDLE) && !sweep_start;

  // Control FSM with all outputs registered; sweep op is frozen at the start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= 3'd0;
      vec_cnt    <= '0;
      hold_cnt   <= 8'd0;
      out_valid  <= 1'b0;
      out_data   <= 1'b0;
      out_vec    <= '0;
      op_err     <= 1'b0;
      sweep_busy <= 1'b0;
      sweep_done <= 1'b0;
`ifdef SWEEP_SIGNATURE_EN
      sweep_sig  <= 16'd0;
`endif
    end else begin
      out_valid  <= 1'b0;
      sweep_done <= 1'b0;
      case (state)
        IDLE: begin
          if (sweep_start) begin
            state      <= SWEEP;
            op_q       <= op;
            vec_cnt    <= '0;
            hold_cnt   <= 8'd0;
            sweep_busy <= 1'b1;
`ifdef SWEEP_SIGNATURE_EN
            sweep_sig  <= 16'd0;
`endif
          end else if (in_valid) begin
            out_valid <= 1'b1;
            out_vec   <= in_data;
            op_err    <= ext_res[1];
            out_data  <= ext_res[0];
          end
        end
        SWEEP: begin
          if (hold_cnt == HOLD_LAST) begin
            out_valid <= 1'b1;
            out_vec   <= vec_cnt[N-1:0];
            op_err    <= sweep_res[1];
            out_data  <= sweep_res[0];
`ifdef SWEEP_SIGNATURE_EN
            sweep_sig <= {sweep_sig[14:0], sweep_res[0]};
`endif
            hold_cnt  <= 8'd0;
            if (vec_cnt == LAST_VEC) begin
              state      <= DONE;
              sweep_done <= 1'b1;
            end else begin
              vec_cnt <= vec_cnt + VEC_ONE;
            end
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        DONE: begin
          state      <= IDLE;
          sweep_busy <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          sweep_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/logic_reduce_sweep_unit.md
Name: logic_reduce_sweep_unit

Overview:
- Parametrised N-input reduction gate: replaces the fixed three-input gates with one block supporting a runtime-selectable operation and a registered output.
- Two sources of input vectors:
  - external single-shot requests via a valid/ready handshake;
  - a built-in sweep engine that walks all 2^N input combinations and produces a full truth table on-chip.
- Used in lab datapaths and as a self-checking gate exerciser.

Parameters:
- N, 3, number of gate inputs (legal range 2..8).
- HOLD_CYCLES, 20, clock cycles each sweep vector is held (legal range 1..255).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- op  in  3  operation select: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6/7 reserved.
- in_valid  in  1  external vector present.
- in_data  in  N  external input vector; bit 0 = first input.
- in_ready  out  1  block can accept an external vector this cycle.
- sweep_start  in  1  one-cycle request to begin a sweep.
- sweep_busy  out  1  high while a sweep is running.
- sweep_done  out  1  one-cycle pulse when a sweep completes.
- out_valid  out  1  one-cycle pulse: out_data/out_vec are new.
- out_data  out  1  reduction result.
- out_vec  out  N  input vector that produced out_data.
- op_err  out  1  registered with out_data; high when op was 6 or 7.

Behaviour:
- Reset (asynchronous, rst_n=0): all of the following are 0 immediately and held 0 while rst_n=0:
  - state=IDLE;
  - out_valid, out_data, out_vec, op_err;
  - sweep_busy, sweep_done;
  - internal vector counter and hold counter.
- States: IDLE, SWEEP, DONE.
- in_ready is combinational = (state==IDLE) && !sweep_start.
- External path:
  - Accept = in_valid && in_ready.
  - Latency 1 cycle: on the edge after accept, out_valid=1, out_vec=in_data, out_data=f(op,in_data).
  - No output backpressure; one result per accepted vector; back-to-back accepts yield back-to-back pulses.
- Reduction f:
  - AND/OR/XOR over all N bits; NAND/NOR/XNOR are their complements.
  - op 6/7: out_data=0, op_err=1. Otherwise op_err=0.
- IDLE to SWEEP:
  - Transition on sweep_start in IDLE.
  - op is latched at this edge and used for the whole sweep; op changes mid-sweep are ignored.
  - Vector counter=0, hold counter=0.
  - sweep_start and in_valid in the same IDLE cycle: sweep wins; the external vector is not accepted.
- SWEEP:
  - sweep_busy=1 and the hold counter increments every cycle.
  - When hold counter==HOLD_CYCLES-1, register the result for the current vector; out_valid pulses the next cycle with out_vec=vector. Then the vector increments and the hold counter clears.
  - After vector 2^N-1 is registered, go to DONE.
  - Sweep length is exactly 2^N*HOLD_CYCLES cycles in SWEEP.
- DONE: sweep_done=1 and sweep_busy=1 for exactly one cycle, then IDLE.
- sweep_start while busy is ignored. Vector counter width is N+1 so the terminal compare does not wrap.
- Reset mid-sweep aborts immediately with no sweep_done. After release, the block is in IDLE with in_ready=1.

Optional Feature:
- Macro: SWEEP_SIGNATURE_EN.
- Defined:
  - Adds output port sweep_sig (out, 16).
  - Cleared at the sweep_start edge.
  - On each sweep result: sweep_sig <= {sweep_sig[14:0], result}, where result is the out_data value.
  - Holds its value after DONE until the next sweep_start or reset.
  - External-path results do not affect it.
  - Reset value 0.
  - For N<=4 it holds the exact truth table, vector 0 in the MSB-most populated bit.
- Undefined: the port and register are absent; all other behaviour is identical.

Test Plan:
1. N=3, HOLD_CYCLES=2. Assert rst_n=0 mid-cycle -> out_valid=0, out_data=0, sweep_busy=0 without waiting for a clock edge; release -> in_ready=1.
2. op=1 (OR):
   - in_data=3'b000 accepted -> next cycle out_valid=1, out_data=0, out_vec=000.
   - Back-to-back in_data=3'b100 -> next cycle out_data=1.
3. op=2 (XOR), in_data=3'b111 -> out_data=1. Then op=3 (NAND), 3'b111 -> out_data=0. Then op=6 -> out_data=0, op_err=1.
4. op=1, pulse sweep_start with in_valid=1 the same cycle:
   - external vector not accepted;
   - sweep_busy high for 17 cycles;
   - 8 out_valid pulses spaced 2 cycles apart, out_vec 0..7, out_data 0,1,1,1,1,1,1,1;
   - single sweep_done pulse;
   - with SWEEP_SIGNATURE_EN, sweep_sig=16'h007F.
5. op=5 (XNOR) sweep:
   - out_data sequence 1,0,0,1,0,1,1,0;
   - changing op to 0 mid-sweep has no effect;
   - sweep_start re-pulsed mid-sweep is ignored (still exactly 8 results).
6. Drop rst_n after the 3rd sweep result -> all outputs 0 immediately and no sweep_done pulse; after release, in_data=3'b010 with op=0 -> out_data=0.
